// File: rtl/uart_proto_pkg.sv
// Constants and types for the UART command/address/data byte protocol.
package uart_proto_pkg;

    localparam logic [7:0] PKT_WRITE_CMD = 8'h41;
    localparam logic [7:0] PKT_READ_CMD  = 8'h42;
    localparam logic [2:0] PKT_ADR_TAG   = 3'b011;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WR_DATA,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_RD_ECHO
    } resp_state_e;

    typedef logic [12:0] word_addr_t;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] base, input word_addr_t wa);
        return base + {17'd0, wa, 2'b00};
    endfunction

endpackage

// File: rtl/uart_mem_responder.sv
// Target side of the UART byte protocol: turns received frames into single-word data-bus accesses.
// Optional UART_RESP_ECHO_CHECK_EN: read-data echoes must match the byte last sent.
//
// state      | meaning
// S_CMD      | idle, waiting for a command byte
// S_ADDR_HI  | waiting for tagged upper address byte
// S_ADDR_LO  | waiting for lower address byte
// S_WR_DATA  | collecting four write data bytes, MSB first
// S_BUS_REQ  | bus request held until grant
// S_BUS_WAIT | waiting for bus response
// S_RD_ECHO  | returning read data, one byte per initiator echo
module uart_mem_responder
    import uart_proto_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_byte_o,
    output logic        req_o,
    input  logic        gnt_i,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    resp_state_e      state;
    logic [4:0]       addr_hi;
    logic             is_write;
    logic             tx_pend;
    logic             rd_last;
    logic [1:0]       cnt;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hold;
    logic             tmo_exp;

    assign be_o     = 4'hF;
    assign wdata_o  = wdata;
    assign busy_o   = (state != S_CMD);
    assign tmo_hold = (state == S_CMD) || (state == S_BUS_REQ) || (state == S_BUS_WAIT);
    assign tmo_exp  = !tmo_hold && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_CMD;
            addr_hi    <= '0;
            is_write   <= 1'b0;
            tx_pend    <= 1'b0;
            rd_last    <= 1'b0;
            cnt        <= '0;
            wdata      <= '0;
            rdata      <= '0;
            tmo_cnt    <= '0;
            tx_start_o <= 1'b0;
            tx_byte_o  <= '0;
            req_o      <= 1'b0;
            we_o       <= 1'b0;
            addr_o     <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            tx_start_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;

            if (tx_pend && !tx_busy_i) begin
                tx_start_o <= 1'b1;
                tx_pend    <= 1'b0;
            end

            if (rx_valid_i || tmo_hold) tmo_cnt <= '0;
            else                        tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                S_CMD: if (rx_valid_i) begin
                    if (rx_byte_i == PKT_WRITE_CMD || rx_byte_i == PKT_READ_CMD) begin
                        is_write  <= (rx_byte_i == PKT_WRITE_CMD);
                        tx_byte_o <= rx_byte_i;
                        tx_pend   <= 1'b1;
                        state     <= S_ADDR_HI;
                    end else begin
                        err_o <= 1'b1;
                    end
                end
                S_ADDR_HI: if (rx_valid_i) begin
                    if (rx_byte_i[7:5] == PKT_ADR_TAG) begin
                        addr_hi   <= rx_byte_i[4:0];
                        tx_byte_o <= rx_byte_i;
                        tx_pend   <= 1'b1;
                        state     <= S_ADDR_LO;
                    end else begin
                        err_o <= 1'b1;
                        state <= S_CMD;
                    end
                end
                S_ADDR_LO: if (rx_valid_i) begin
                    addr_o <= word_byte_addr(BASE_ADDR, {addr_hi, rx_byte_i});
                    if (is_write) begin
                        tx_byte_o <= rx_byte_i;
                        tx_pend   <= 1'b1;
                        cnt       <= 2'd3;
                        state     <= S_WR_DATA;
                    end else begin
                        req_o <= 1'b1;
                        we_o  <= 1'b0;
                        state <= S_BUS_REQ;
                    end
                end
                S_WR_DATA: if (rx_valid_i) begin
                    wdata[{cnt, 3'b000} +: 8] <= rx_byte_i;
                    if (cnt != 2'd0) begin
                        tx_byte_o <= rx_byte_i;
                        tx_pend   <= 1'b1;
                        cnt       <= cnt - 2'd1;
                    end else begin
                        // last data byte is not echoed; the initiator moves straight on
                        req_o <= 1'b1;
                        we_o  <= 1'b1;
                        state <= S_BUS_REQ;
                    end
                end
                S_BUS_REQ: begin
                    if (rx_valid_i) err_o <= 1'b1;
                    if (gnt_i) begin
                        req_o <= 1'b0;
                        we_o  <= 1'b0;
                        state <= S_BUS_WAIT;
                    end
                end
                S_BUS_WAIT: begin
                    if (rx_valid_i) err_o <= 1'b1;
                    if (rvalid_i) begin
                        done_o <= 1'b1;
                        if (is_write) begin
                            state <= S_CMD;
                        end else begin
                            rdata     <= rdata_i;
                            tx_byte_o <= rdata_i[31:24];
                            tx_pend   <= 1'b1;
                            cnt       <= 2'd2;
                            rd_last   <= 1'b0;
                            state     <= S_RD_ECHO;
                        end
                    end
                end
                S_RD_ECHO: if (rx_valid_i) begin
`ifdef UART_RESP_ECHO_CHECK_EN
                    if (rx_byte_i != tx_byte_o) begin
                        err_o   <= 1'b1;
                        tx_pend <= 1'b0;
                        state   <= S_CMD;
                    end else
`endif
                    if (rd_last) begin
                        state <= S_CMD;
                    end else begin
                        tx_byte_o <= rdata[{cnt, 3'b000} +: 8];
                        tx_pend   <= 1'b1;
                        if (cnt == 2'd0) rd_last <= 1'b1;
                        else             cnt     <= cnt - 2'd1;
                    end
                end
                default: state <= S_CMD;
            endcase

            // an arriving byte always beats an expiring timer
            if (!rx_valid_i && tmo_exp) begin
                err_o   <= 1'b1;
                tx_pend <= 1'b0;
                state   <= S_CMD;
            end
        end
    end

endmodule

// File: doc/uart_mem_responder.md
Name: uart_mem_responder

Overview:
- Target-side end of the 8-bit command/address/data byte protocol driven by the UART controller initiator.
- Sits behind a byte-level UART instance and turns received frames into single 32-bit word accesses on an Ibex-style data bus.
- Writes: echoes header and data bytes, then writes memory.
- Reads: fetches the word from memory and returns it MSB first, one byte per initiator echo.

Parameters:
- BASE_ADDR, 32'h0000_0000, bus byte address of protocol word address 0.
- TIMEOUT_CYCLES, 1_000_000, idle cycles mid-frame before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rx_valid_i  in  1  one-cycle pulse, byte received from UART
- rx_byte_i  in  8  received byte, valid with rx_valid_i
- tx_busy_i  in  1  UART transmitter busy
- tx_start_o  out  1  one-cycle transmit request
- tx_byte_o  out  8  byte to transmit, held stable from tx_start_o until tx_busy_i falls
- req_o  out  1  bus request
- gnt_i  in  1  bus grant
- we_o  out  1  bus write enable
- be_o  out  4  byte enables, constant 4'hF
- addr_o  out  32  BASE_ADDR + {addr13, 2'b00}
- wdata_o  out  32  assembled write word
- rvalid_i  in  1  bus response valid
- rdata_i  in  32  bus read data
- busy_o  out  1  high in any state except S_CMD
- done_o  out  1  one-cycle pulse when a bus access completes
- err_o  out  1  one-cycle pulse on protocol error or timeout

Behaviour:
- Reset: all outputs 0, state S_CMD, counters and registers 0. Reset mid-frame aborts immediately; no bus transaction survives reset.
- Tx rule: a byte to send is queued in tx_pend. tx_start_o pulses for one cycle on the first cycle with tx_pend && !tx_busy_i, then tx_pend clears. At most one byte is pending, because the initiator waits for each reply.
- S_CMD:
  - 0x41 -> latch write, queue echo 0x41, go to S_ADDR_HI.
  - 0x42 -> latch read, queue echo 0x42, go to S_ADDR_HI.
  - Any other byte -> err_o, stay.
- S_ADDR_HI:
  - byte[7:5]==3'b011 -> addr13[12:8]=byte[4:0], queue echo, go to S_ADDR_LO.
  - Otherwise -> err_o, go to S_CMD.
- S_ADDR_LO: addr13[7:0]=byte.
  - Write -> queue echo, cnt=3, go to S_WR_DATA.
  - Read -> go to S_BUS_REQ.
- S_WR_DATA: each byte fills wdata[8*cnt +: 8].
  - cnt>0 -> queue echo, decrement cnt.
  - cnt==0 -> no echo (the initiator does not wait for one), go to S_BUS_REQ.
- S_BUS_REQ: req_o=1 with we_o/addr_o/wdata_o stable until the gnt_i cycle, then go to S_BUS_WAIT.
- S_BUS_WAIT: on rvalid_i, pulse done_o.
  - Write -> go to S_CMD.
  - Read -> capture rdata_i, queue rdata[31:24], cnt=2, go to S_RD_ECHO.
- S_RD_ECHO: on each rx byte (the initiator's echo):
  - cnt>=0 with bytes remaining -> queue rdata[8*cnt +: 8], decrement.
  - Echo of byte [7:0] -> go to S_CMD.
- Bytes received in S_BUS_REQ/S_BUS_WAIT are dropped and pulse err_o; state is unaffected.
- Timeout: the counter resets on every rx_valid_i and while in S_CMD, S_BUS_REQ or S_BUS_WAIT. Reaching TIMEOUT_CYCLES pulses err_o, clears tx_pend and goes to S_CMD.
- Simultaneous rx_valid_i and timeout expiry: the byte wins and the counter clears.
- Latency: the echo tx_start_o fires 2 cycles after rx_valid_i when the transmitter is idle.

Optional Feature:
- UART_RESP_ECHO_CHECK_EN.
- Defined: in S_RD_ECHO the received byte must equal the last byte sent. On mismatch, pulse err_o, go to S_CMD and send nothing further.
- Undefined: any byte is accepted as the echo.

Decomposition:
- Package uart_proto_pkg holds:
  - constants PKT_WRITE_CMD=8'h41, PKT_READ_CMD=8'h42, PKT_ADR_TAG=3'b011;
  - the state enum typedef;
  - the 13-bit word address typedef.
- No sub-module. The timeout counter stays inline. The UART byte transceiver is instantiated alongside in the wrapper, not inside this block.

Test Plan:
- Write: rx 41,61,23,DE,AD,BE,EF -> tx echoes 41,61,23,DE,AD,BE only; one bus write at addr 0x48C, wdata 0xDEADBEEF, be F; done_o pulses once.
- Read: rx 42,60,05; bus returns 0x12345678 -> tx 12; after each echo, tx 34, 56, 78; final echo returns to S_CMD with busy_o=0.
- Bad header: rx 55 -> err_o pulses, no tx; rx 41 then 80 -> err_o, back to S_CMD, no bus request.
- Timeout: rx 41 then silence for TIMEOUT_CYCLES (sim value 100) -> err_o at cycle 100, S_CMD; a fresh write completes normally afterwards.
- Backpressure/reset: gnt_i held low 20 cycles keeps req_o and addr_o stable; rst_ni asserted in S_WR_DATA clears all outputs asynchronously.
- With UART_RESP_ECHO_CHECK_EN defined: read returning echo 0x00 instead of 0x12 -> err_o pulses, no further tx.
